// File: rtl/load_unit_if.sv
// Data-memory read port of the load unit: word-addressed request with a
// ready/data return.
interface load_unit_if #(
    parameter int ADDR_W = 10
);
    logic              dm_req;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_rdata;
    logic              dm_ready;

    modport master (
        output dm_req,
        output dm_addr,
        input  dm_rdata,
        input  dm_ready
    );

    modport slave (
        input  dm_req,
        input  dm_addr,
        output dm_rdata,
        output dm_ready
    );
endinterface

// File: rtl/load_unit.sv
// MEM-stage load unit: issues a word read to a variable-latency data memory,
// stalls the pipeline while it is outstanding, and returns an aligned,
// extended result to WB. Flags misaligned loads and memory timeouts.
module load_unit #(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_req,
    input  logic [2:0]  Load_mem,
    input  logic [31:0] aluout_mem,
    input  logic [4:0]  a3_mem,
    load_unit_if.master dm,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_a3,
    output logic        adel,
    output logic        dm_err
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    typedef enum logic [0:0] {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        a3_q, a3_d;
    logic              wb_valid_q, wb_valid_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic [4:0]        wb_a3_q, wb_a3_d;
    logic              adel_q, adel_d;
    logic              dm_err_q, dm_err_d;

    logic type_ok;
    logic misaligned;

    // Only the word-address bits reach the memory; the rest are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^aluout_mem[31:ADDR_W+2];

    function automatic logic [31:0] extend(input logic [2:0]  op,
                                           input logic [1:0]  off,
                                           input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (op)
            OP_LH:   extend = {{16{h[15]}}, h};
            OP_LHU:  extend = {16'h0000, h};
            OP_LB:   extend = {{24{b[7]}}, b};
            OP_LBU:  extend = {24'h000000, b};
            default: extend = w;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        op_d       = op_q;
        off_d      = off_q;
        a3_d       = a3_q;
        wb_data_d  = wb_data_q;
        wb_a3_d    = wb_a3_q;
        wb_valid_d = 1'b0;
        adel_d     = 1'b0;
        dm_err_d   = 1'b0;
        stall      = 1'b0;

        type_ok = (Load_mem <= OP_LBU);
        case (Load_mem)
            OP_LW:         misaligned = |aluout_mem[1:0];
            OP_LH, OP_LHU: misaligned = aluout_mem[0];
            default:       misaligned = 1'b0;
        endcase

        case (state_q)
            S_IDLE: begin
                if (load_req && type_ok) begin
                    if (misaligned) begin
                        adel_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 8'd0;
                        addr_d  = aluout_mem[ADDR_W+1:2];
                        op_d    = Load_mem;
                        off_d   = aluout_mem[1:0];
                        a3_d    = a3_mem;
                        stall   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + 8'd1;
                // A response in the last allowed cycle still wins over timeout.
                if (dm.dm_ready) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = extend(op_q, off_q, dm.dm_rdata);
                    wb_a3_d    = a3_q;
                    state_d    = S_IDLE;
                    cnt_d      = 8'd0;
                end else if (cnt_q == LAST_WAIT) begin
                    dm_err_d = 1'b1;
                    state_d  = S_IDLE;
                    cnt_d    = 8'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: asynchronous reset clears every register, including the captured
    // address and result, so all outputs read zero straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= '0;
            op_q       <= 3'b000;
            off_q      <= 2'b00;
            a3_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= 32'd0;
            wb_a3_q    <= 5'd0;
            adel_q     <= 1'b0;
            dm_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            off_q      <= off_d;
            a3_q       <= a3_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_a3_q    <= wb_a3_d;
            adel_q     <= adel_d;
            dm_err_q   <= dm_err_d;
        end
    end

    assign dm.dm_req  = (state_q == S_WAIT);
    assign dm.dm_addr = addr_q;
    assign wb_valid   = wb_valid_q;
    assign wb_data    = wb_data_q;
    assign wb_a3      = wb_a3_q;
    assign adel       = adel_q;
    assign dm_err     = dm_err_q;

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed cases followed by randomized
// loads, all checked against a behavioural model of the load semantics.
module tb_load_unit;

    localparam int ADDR_W   = 10;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_req;
    logic [2:0]  load_mem;
    logic [31:0] aluout_mem;
    logic [4:0]  a3_mem;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_a3;
    logic        adel;
    logic        dm_err;

    load_unit_if #(.ADDR_W(ADDR_W)) dm ();

    always #5 clk = ~clk;

    load_unit #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_req  (load_req),
        .Load_mem  (load_mem),
        .aluout_mem(aluout_mem),
        .a3_mem    (a3_mem),
        .dm        (dm),
        .stall     (stall),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .wb_a3     (wb_a3),
        .adel      (adel),
        .dm_err    (dm_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model of what WB should see at the next sample point.
    bit          pend_wb, pend_adel, pend_err;
    logic [31:0] exp_data;
    logic [4:0]  exp_a3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_mis(input int op, input logic [31:0] addr);
        if (op == 0) return (addr % 4) != 0;
        if (op == 1 || op == 2) return (addr % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_ext(input int op, input logic [31:0] addr,
                                              input logic [31:0] w);
        int unsigned off;
        longint      v;
        off = addr % 4;
        case (op)
            1, 2: begin
                v = (w >> (16 * (off / 2))) % 65536;
                if (op == 1 && v >= 32768) v = v - 65536;
            end
            3, 4: begin
                v = (w >> (8 * off)) % 256;
                if (op == 3 && v >= 128) v = v - 256;
            end
            default: v = w;
        endcase
        return 32'(v);
    endfunction

    task automatic step_check();
        check("wb_valid", wb_valid, pend_wb);
        check("adel", adel, pend_adel);
        check("dm_err", dm_err, pend_err);
        check("wb_data", wb_data, exp_data);
        check("wb_a3", wb_a3, exp_a3);
        pend_wb   = 0;
        pend_adel = 0;
        pend_err  = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dm_req"}, dm.dm_req, 0);
        check({tag, "_dm_addr"}, dm.dm_addr, 0);
        check({tag, "_wb_valid"}, wb_valid, 0);
        check({tag, "_wb_data"}, wb_data, 0);
        check({tag, "_wb_a3"}, wb_a3, 0);
        check({tag, "_adel"}, adel, 0);
        check({tag, "_dm_err"}, dm_err, 0);
        check({tag, "_stall"}, stall, 0);
    endtask

    task automatic idle_cycle(input bit ready);
        @(negedge clk);
        load_req    = 1'b0;
        load_mem    = 3'($urandom);
        aluout_mem  = $urandom;
        a3_mem      = 5'($urandom);
        dm.dm_ready = ready;
        dm.dm_rdata = $urandom;
        #1;
        step_check();
        check("idle_stall", stall, 0);
        check("idle_dm_req", dm.dm_req, 0);
    endtask

    // lat = WAIT cycle in which dm_ready is given; 0 or > MAX_WAIT means never.
    task automatic do_load(input int op, input logic [31:0] addr, input logic [4:0] a3,
                           input logic [31:0] rdata, input int lat, input int abort_at = 0);
        logic [ADDR_W-1:0] exp_addr;
        @(negedge clk);
        load_req    = 1'b1;
        load_mem    = 3'(op);
        aluout_mem  = addr;
        a3_mem      = a3;
        dm.dm_ready = 1'b0;
        dm.dm_rdata = $urandom;
        #1;
        step_check();
        check("req_dm_req", dm.dm_req, 0);
        if (op > 4 || model_mis(op, addr)) begin
            check("req_stall_none", stall, 0);
            pend_adel = (op <= 4);
            return;
        end
        check("req_stall", stall, 1);
        exp_addr = addr[ADDR_W+1:2];
        for (int k = 1; k <= MAX_WAIT; k++) begin
            @(negedge clk);
            load_req    = 1'($urandom);
            load_mem    = 3'($urandom);
            aluout_mem  = $urandom;
            a3_mem      = 5'($urandom);
            dm.dm_ready = (k == lat);
            dm.dm_rdata = (k == lat) ? rdata : $urandom;
            #1;
            step_check();
            check("wait_dm_req", dm.dm_req, 1);
            check("wait_stall", stall, 1);
            check("wait_dm_addr", dm.dm_addr, exp_addr);
            if (k == abort_at) begin
                load_req = 1'b0;
                reset_n  = 1'b0;
                #1;
                exp_data = 0;
                exp_a3   = 0;
                check_all_zero("abort");
                @(negedge clk);
                reset_n     = 1'b1;
                dm.dm_ready = 1'b0;
                return;
            end
            if (k == lat) begin
                pend_wb  = 1;
                exp_data = model_ext(op, addr, rdata);
                exp_a3   = a3;
                return;
            end
        end
        pend_err = 1;
    endtask

    initial begin
        int op, lat;
        logic [31:0] addr;

        reset_n     = 1'b0;
        load_req    = 1'b0;
        load_mem    = 3'b000;
        aluout_mem  = 32'd0;
        a3_mem      = 5'd0;
        dm.dm_ready = 1'b0;
        dm.dm_rdata = 32'd0;
        pend_wb = 0; pend_adel = 0; pend_err = 0;
        exp_data = 0; exp_a3 = 0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Word load with single-cycle memory.
        do_load(0, 32'h0000_0010, 5'd8, 32'hDEAD_BEEF, 1);
        idle_cycle(0);

        // Extension sweep over one fixed word.
        do_load(3, 32'h0000_0103, 5'd1, 32'h8012_F07F, 1);
        do_load(4, 32'h0000_0103, 5'd2, 32'h8012_F07F, 1);
        do_load(3, 32'h0000_0100, 5'd3, 32'h8012_F07F, 2);
        do_load(1, 32'h0000_0102, 5'd4, 32'h8012_F07F, 1);
        do_load(2, 32'h0000_0100, 5'd5, 32'h8012_F07F, 3);
        idle_cycle(0);

        // Misaligned and reserved types.
        do_load(0, 32'h0000_0002, 5'd6, 32'h1111_1111, 1);
        do_load(1, 32'h0000_0001, 5'd7, 32'h2222_2222, 1);
        do_load(6, 32'h0000_0003, 5'd9, 32'h3333_3333, 1);
        idle_cycle(1);

        // Slow memory, then timeout followed immediately by a new load.
        do_load(0, 32'h0000_0FFC, 5'd10, 32'hCAFE_0001, 5);
        do_load(0, 32'h0000_0020, 5'd11, 32'hCAFE_0002, 0);
        do_load(4, 32'h0000_0021, 5'd12, 32'hCAFE_0003, 1);
        idle_cycle(0);

        // Reset in the middle of WAIT, then a stray dm_ready.
        do_load(0, 32'h0000_0040, 5'd13, 32'h5555_AAAA, 0, 4);
        idle_cycle(1);
        idle_cycle(0);
        check_all_zero("post_abort");

        // Back-to-back immediate loads, then ready in the last allowed cycle.
        do_load(0, 32'h0000_0044, 5'd14, 32'h0123_4567, 1);
        do_load(1, 32'h0000_0046, 5'd15, 32'h89AB_CDEF, 1);
        do_load(0, 32'h0000_0048, 5'd16, 32'h7777_0000, MAX_WAIT);
        idle_cycle(0);

        for (int i = 0; i < 200; i++) begin
            op   = $urandom_range(0, 7);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (op == 0) addr[1:0] = 2'b00;
                if (op == 1 || op == 2) addr[0] = 1'b0;
            end
            lat = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 3)
                                              : $urandom_range(1, MAX_WAIT + 2);
            do_load(op, addr, 5'($urandom), $urandom, lat);
            if ($urandom_range(0, 2) == 0) idle_cycle(1'($urandom));
        end
        idle_cycle(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Read-side counterpart of the MEM-stage store path.
- Accepts a load request from the MEM stage and issues a word read to a variable-latency data memory using a req/ready handshake.
- Stalls the pipeline while the read is outstanding, then aligns and sign/zero-extends the returned word and presents a registered result and destination register to WB.
- Detects misaligned loads and memory timeouts.

Parameters:
- ADDR_W, 10: word-address width driven to the data memory (byte address bits [ADDR_W+1:2]).
- MAX_WAIT, 15: number of WAIT cycles without dm_ready before a bus error is declared (1..255).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- load_req  in  1  MEM stage holds a load this cycle
- Load_mem  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101-111 reserved
- aluout_mem  in  32  byte address
- a3_mem  in  5  destination register
- dm_req  out  1  read request to data memory
- dm_addr  out  ADDR_W  word address = latched aluout_mem[ADDR_W+1:2]
- dm_rdata  in  32  read data, valid when dm_ready=1
- dm_ready  in  1  read data valid/accept
- stall  out  1  freeze IF/ID/EX/MEM
- wb_valid  out  1  one-cycle pulse, wb_data/wb_a3 valid
- wb_data  out  32  extended load result
- wb_a3  out  5  destination register of result
- adel  out  1  one-cycle pulse, misaligned load
- dm_err  out  1  one-cycle pulse, memory timeout

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, wait counter=0.
  - dm_req=0, dm_addr=0, wb_valid=0, wb_data=0, wb_a3=0, adel=0, dm_err=0.
  - Reset mid-WAIT aborts the read; no wb_valid or dm_err pulse follows.
- Alignment:
  - Misaligned when lw has addr[1:0]!=0, or lh/lhu has addr[0]!=0. lb/lbu are never misaligned.
- States: IDLE, WAIT.
- IDLE:
  - If load_req=0 or Load_mem is reserved: nothing happens, stall=0.
  - If load_req=1 and misaligned: adel=1 on the next cycle for one cycle, no memory request, stay IDLE, stall=0.
  - If load_req=1, aligned and valid type: latch type, addr[1:0], a3 and word address; go to WAIT. stall=1 combinationally in this cycle.
- WAIT:
  - dm_req=1 and stall=1. dm_addr is held stable for the whole state.
  - load_req and the MEM inputs are ignored.
  - Counter increments each cycle in WAIT.
  - dm_ready=1: capture extended dm_rdata into wb_data, latched a3 into wb_a3, wb_valid=1 next cycle, go to IDLE, counter=0.
  - Counter reaches MAX_WAIT with dm_ready=0: dm_err=1 next cycle, wb_valid stays 0, go to IDLE.
  - dm_ready has priority over timeout when both occur in the same cycle.
- stall deasserts in the cycle wb_valid rises.
- Latency: request cycle T enters WAIT at T+1. dm_ready at T+1 gives wb_valid at T+2 (minimum 2 cycles).
- A new request is accepted in the same IDLE cycle that wb_valid, adel or dm_err is high. Back-to-back loads are therefore spaced by at least 2 cycles.
- Extension, with off = latched addr[1:0]:
  - lw: the word as returned.
  - lb/lbu: byte dm_rdata[8*off+7:8*off], sign- or zero-extended to 32 bits.
  - lh/lhu: half dm_rdata[16*off[1]+15:16*off[1]], sign- or zero-extended.
- wb_valid, adel and dm_err are mutually exclusive and each is high for exactly one cycle.
- wb_data and wb_a3 hold their value until the next wb_valid.

Test Plan:
- Word load: lw, addr 0x0000_0010, a3=8, dm_ready 1 cycle after dm_req, rdata 0xDEAD_BEEF -> dm_addr=4; stall high for 2 cycles; wb_valid with wb_data=0xDEAD_BEEF, wb_a3=8.
- Extension: rdata 0x8012_F07F, sweeping type and address:
  - lb @+3 -> 0xFFFF_FF80
  - lbu @+3 -> 0x0000_0080
  - lb @+0 -> 0x0000_007F
  - lh @+2 -> 0xFFFF_8012
  - lhu @+0 -> 0x0000_F07F
- Misaligned: lw @0x0000_0002 and lh @0x0000_0001 -> adel pulse each time; dm_req never asserted; stall=0; no wb_valid.
- Slow memory and timeout:
  - dm_ready after 5 WAIT cycles -> stall high 6 cycles, dm_addr stable throughout.
  - dm_ready never asserted -> dm_err after MAX_WAIT=15 cycles, wb_valid=0, next load accepted.
- Reset mid-op: reset_n low during WAIT, then release, then assert dm_ready -> no wb_valid, state IDLE, all outputs 0.
- Back-to-back and priority: two loads with dm_ready immediate -> second request accepted in the wb_valid cycle. dm_ready in the MAX_WAIT cycle -> wb_valid, not dm_err.
